mips_hazard_ctrl: RTL
=====================

Name: mips_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB).
- Sequences PC and IF/ID write enables, ID/EX bubble insertion and younger-stage flushes for three cases: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits.
- Sits beside the pipeline registers; all hazard-related enables come from this block.

Parameters:
- LU_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..15).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before mem_timeout asserts (1..255).
- CNT_W, 16: performance counter width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  synchronous active-low reset.
- id_rs  in  5  IF/ID instruction bits [25:21].
- id_rt  in  5  IF/ID instruction bits [20:16].
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  ID/EX MemRead.
- ex_rt  in  5  ID/EX instruction bits [20:16] (load destination).
- mem_pc_src  in  1  taken branch in MEM (Branch & zero).
- dmem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_bubble  out  1  ID/EX control bits zeroed.
- ex_mem_flush  out  1  EX/MEM control bits zeroed.
- pipe_freeze  out  1  hold EX/MEM and MEM/WB.
- hz_state  out  2  current FSM state.
- mem_timeout  out  1  sticky wait-timeout flag.
- stall_cycles  out  CNT_W  stall cycle count.
- flush_count  out  CNT_W  branch flush count.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous, active-low, port RST_N.
- Reset: state = RUN, stall counter = 0, saved state = RUN, wait counter = 0, mem_timeout = 0, perf counters = 0.
- While RST_N = 0: pc_write = 0, if_id_write = 0, and if_id_flush, id_ex_bubble and ex_mem_flush = 1, so the pipeline fills with bubbles. pipe_freeze = 0.
- Control outputs are combinational from the registered state plus current inputs, so the response occurs in the same cycle as the hazard. The state register updates on the next edge.
- State encoding: RUN = 0, STALL = 1, MEM_WAIT = 2. Value 3 is illegal and recovers to RUN.
- lu_hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Priority within every state: dmem_busy > mem_pc_src > lu_hazard / STALL hold.
- Freeze (dmem_busy = 1):
  - pipe_freeze = 1, pc_write = 0, if_id_write = 0; all flush/bubble outputs = 0.
  - Saved state and stall counter are latched on entry.
  - Next state = MEM_WAIT.
- Branch (mem_pc_src = 1, not busy):
  - pc_write = 1 (loads the branch target), if_id_write = 1.
  - if_id_flush = 1, id_ex_bubble = 1, ex_mem_flush = 1.
  - Any pending stall is cancelled: stall counter = 0, next state = RUN.
- Load-use hazard in RUN: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
  - If LU_STALL_CYCLES = 1, next state = RUN.
  - Otherwise stall counter = LU_STALL_CYCLES - 1, next state = STALL.
- STALL: same outputs as a load-use hazard; counter decrements each cycle; leaves to RUN on the cycle the counter equals 1.
- Idle RUN: pc_write = 1, if_id_write = 1, all others 0.
- MEM_WAIT:
  - Outputs as freeze while dmem_busy = 1.
  - Wait counter increments and saturates. When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset. The block keeps waiting.
  - First cycle with dmem_busy = 0: outputs are evaluated as in the saved state with current inputs; wait counter clears; the stall counter resumes unchanged.
- mem_pc_src is ignored while frozen; the branch stays in MEM and is acted on after the release.
- hz_state reflects the registered state.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every non-reset cycle with pc_write = 0.
  - flush_count increments on every cycle with if_id_flush = 1 outside reset.
  - Both counters saturate at all-ones.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Decomposition:
- Package mips_hazard_pkg holds:
  - hz_state_t enum: RUN, STALL, MEM_WAIT.
  - REG_ADDR_W = 5.
  - HZ_STATE_W = 2.
  - Zero-register constant.
- Sub-module mips_load_use_detect: purely combinational lu_hazard comparator, reusable for a later forwarding unit.

Test Plan:
1. Reset: RST_N = 0 for 2 cycles with dmem_busy = 0 -> pc_write = 0 and all flushes = 1. After release -> hz_state = 0, pc_write = 1, mem_timeout = 0, counters 0.
2. Load-use: ex_mem_read = 1, ex_rt = 8, id_rs = 8 -> exactly 1 cycle of pc_write = 0 and id_ex_bubble = 1. With LU_STALL_CYCLES = 3 -> 3 cycles, hz_state = 1 for 2 of them. With ex_rt = 0 -> no stall.
3. Branch flush during STALL (LU_STALL_CYCLES = 3): mem_pc_src = 1 on the 2nd stall cycle -> that cycle if_id_flush = id_ex_bubble = ex_mem_flush = 1 and pc_write = 1; next hz_state = 0.
4. Memory wait: dmem_busy = 1 for 4 cycles with mem_pc_src = 1 -> pipe_freeze = 1 for 4 cycles with no flush. On release -> flush asserted 1 cycle and flush_count = 1 (macro defined).
5. Timeout: MEM_TIMEOUT = 5, dmem_busy held 7 cycles -> mem_timeout rises after the 5th MEM_WAIT cycle and stays 1 after release until reset.
6. Macro off: repeat scenario 2 -> stall_cycles = flush_count = 0 throughout.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Optional perf counters in the top are enabled by HAZARD_PERF_CNT_EN.
package mips_hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int HZ_STATE_W = 2;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [HZ_STATE_W-1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/mips_load_use_detect.sv
// Combinational load-use comparator between the ID and EX stages.
// Kept standalone so a forwarding unit can reuse it.
module mips_load_use_detect
  import mips_hazard_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  lu_hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt & (ex_rt == id_rt);

  assign lu_hazard = ex_mem_read
                   & (ex_rt != ZERO_REG)
                   & (rs_hit | rt_hit);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Hazard controller: load-use stalls, MEM-stage branch flushes, dmem waits.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module mips_hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  mem_pc_src,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_flush,
  output logic                  pipe_freeze,
  output logic [HZ_STATE_W-1:0] hz_state,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int SC_W = 4;
  localparam int WC_W = 8;
  localparam logic [SC_W-1:0] LU_INIT = SC_W'(LU_STALL_CYCLES - 1);
  localparam logic [WC_W-1:0] TO_VAL  = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_MAX  = '1;

  hz_state_t       state, state_nxt;
  hz_state_t       saved, saved_nxt;
  hz_state_t       eff;
  logic [SC_W-1:0] scnt, scnt_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;
  logic            to_nxt;
  logic            lu_hazard;

  mips_load_use_detect u_lud (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .lu_hazard   (lu_hazard)
  );

  // On release from MEM_WAIT the pre-freeze state decides the outputs.
  assign eff = (state == MEM_WAIT) ? saved : state;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_freeze  = 1'b0;
    state_nxt    = RUN;
    saved_nxt    = saved;
    scnt_nxt     = scnt;
    wcnt_nxt     = '0;
    to_nxt       = mem_timeout;
    if (!RST_N) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (dmem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_nxt   = MEM_WAIT;
      if (state != MEM_WAIT) begin
        saved_nxt = (state == STALL) ? STALL : RUN;
      end else begin
        wcnt_nxt = (wcnt == WC_MAX) ? wcnt : wcnt + 1'b1;
        if (wcnt_nxt >= TO_VAL) to_nxt = 1'b1;
      end
    end else if (mem_pc_src) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      scnt_nxt     = '0;
    end else if (eff == STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      scnt_nxt     = scnt - 1'b1;
      state_nxt    = (scnt <= 1) ? RUN : STALL;
    end else if (lu_hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        scnt_nxt  = LU_INIT;
        state_nxt = STALL;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= RUN;
      saved       <= RUN;
      scnt        <= '0;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      saved       <= saved_nxt;
      scnt        <= scnt_nxt;
      wcnt        <= wcnt_nxt;
      mem_timeout <= to_nxt;
    end
  end

  assign hz_state = state;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && flush_count != CNT_MAX)
        flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
